modulo_arbiter: RTL and testbench

MODULO_ARBITER -- requirements
Module: modulo_arbiter

---
 rtl/modulo_arb_pkg.sv | 23 ++
 rtl/rr_picker.sv | 44 ++++
 rtl/modulo_arbiter.sv | 179 +++++++++++++++++
 tb/tb_modulo_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/modulo_arb_pkg.sv
// Shared definitions for the modulo arbiter slice.
//
// Holds the default width/count constants used as parameter defaults by
// modulo_arbiter, the arbiter state type and a small index-width helper.
package modulo_arb_pkg;

  localparam int DEFAULT_DATA_WIDTH     = 8;
  localparam int DEFAULT_NUM_REQ        = 4;
  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
//
// Chooses the lowest valid index strictly after last_grant, wrapping
// around NUM_REQ, and reports it both one-hot and as a binary index.
//
// Ports:
//   valid      in   NUM_REQ  request vector
//   last_grant in   IDX_W    index granted most recently
//   grant      out  NUM_REQ  one-hot pick (all zero when nothing valid)
//   grant_idx  out  IDX_W    binary index of the pick
//   any_valid  out  1        at least one request is valid
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_valid
);

  // Walk offsets 1..NUM_REQ so that last_grant itself is considered last;
  // the first valid candidate found wins.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand     = (int'(last_grant) + off) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!any_valid && valid[cand_idx]) begin
        any_valid       = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/modulo_arbiter.sv
// Round-robin arbiter that shares one external modulo unit between
// NUM_REQ requesters, one operation in flight at a time.
//
// Optional feature: define MODULO_ARBITER_WATCHDOG_EN to bound the wait
// for mod_done to TIMEOUT_CYCLES; a timed-out operation answers with
// rsp_err=1 and rsp_data=0. Without it, the wait is unbounded and
// rsp_err is tied low.
//
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   req_valid     per-requester request, held until req_ready
//   req_a         per-requester operand (2*DATA_WIDTH+1 bits)
//   req_mod       per-requester modulus (DATA_WIDTH bits)
//   req_ready     one-hot acceptance strobe (IDLE only)
//   rsp_valid     one-hot, one-cycle result strobe
//   rsp_data      shared result bus, valid with rsp_valid
//   rsp_err       error qualifier for rsp_data
//   mod_start     one-cycle start pulse to the modulo unit
//   mod_a         operand to the modulo unit
//   mod_modulant  modulus to the modulo unit
//   mod_out       result from the modulo unit
//   mod_done      level done from the modulo unit
module modulo_arbiter
  import modulo_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int NUM_REQ        = DEFAULT_NUM_REQ,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ-1:0][2*DATA_WIDTH:0]   req_a,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_mod,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic [NUM_REQ-1:0]                   rsp_valid,
  output logic [DATA_WIDTH-1:0]                rsp_data,
  output logic                                 rsp_err,
  output logic                                 mod_start,
  output logic [2*DATA_WIDTH:0]                mod_a,
  output logic [DATA_WIDTH-1:0]                mod_modulant,
  input  logic [DATA_WIDTH-1:0]                mod_out,
  input  logic                                 mod_done
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int OPW   = 2 * DATA_WIDTH + 1;

  arb_state_e             state;
  arb_state_e             next_state;
  logic [IDX_W-1:0]       last_grant;
  logic [IDX_W-1:0]       cap_idx;
  logic [OPW-1:0]         cap_a;
  logic [DATA_WIDTH-1:0]  cap_mod;
  logic [DATA_WIDTH-1:0]  result_q;
  logic                   first_wait;
  logic                   leave_wait;

  logic [NUM_REQ-1:0]     pick_onehot;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .valid      (req_valid),
    .last_grant (last_grant),
    .grant      (pick_onehot),
    .grant_idx  (pick_idx),
    .any_valid  (pick_any)
  );

`ifdef MODULO_ARBITER_WATCHDOG_EN
  localparam int             WD_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_expire;
  logic            err_q;
`endif

  // Next-state logic. The unit's done level is stale during the first WAIT
  // cycle (the start pulse has only just been registered), so it is only
  // trusted from the second WAIT cycle onward.
  always_comb begin
    next_state = state;
    leave_wait = 1'b0;
`ifdef MODULO_ARBITER_WATCHDOG_EN
    wd_expire  = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (pick_any) next_state = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (!first_wait && mod_done) begin
          leave_wait = 1'b1;
        end
`ifdef MODULO_ARBITER_WATCHDOG_EN
        else if (wd_cnt == WD_LIMIT) begin
          leave_wait = 1'b1;
          wd_expire  = 1'b1;
        end
`endif
        if (leave_wait) next_state = ST_RESP;
      end
      ST_RESP: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Strobes are masked while reset is asserted so that a reset cycle never
  // shows an acceptance, a start or a response.
  assign req_ready    = (state == ST_IDLE && !reset) ? pick_onehot : '0;
  assign mod_start    = (state == ST_LAUNCH) && !reset;
  assign rsp_valid    = (state == ST_RESP && !reset) ? (NUM_REQ'(1) << cap_idx) : '0;
  assign rsp_data     = result_q;
  assign mod_a        = cap_a;
  assign mod_modulant = cap_mod;

  // State register, operand capture at grant time and result latch on the
  // way out of WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= IDX_W'(NUM_REQ - 1);
      cap_idx    <= '0;
      cap_a      <= '0;
      cap_mod    <= '0;
      result_q   <= '0;
      first_wait <= 1'b0;
    end else begin
      state      <= next_state;
      first_wait <= (state == ST_LAUNCH);
      if (state == ST_IDLE && pick_any) begin
        cap_idx    <= pick_idx;
        cap_a      <= req_a[pick_idx];
        cap_mod    <= req_mod[pick_idx];
        last_grant <= pick_idx;
      end
      if (leave_wait) begin
`ifdef MODULO_ARBITER_WATCHDOG_EN
        result_q <= wd_expire ? '0 : mod_out;
`else
        result_q <= mod_out;
`endif
      end
    end
  end

`ifdef MODULO_ARBITER_WATCHDOG_EN
  // Watchdog counts WAIT cycles; the error flag is only meaningful during
  // the RESP cycle and is cleared as RESP is left.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == ST_WAIT) wd_cnt <= wd_cnt + 1'b1;
      else                  wd_cnt <= '0;
      if (leave_wait)             err_q <= wd_expire;
      else if (state == ST_RESP)  err_q <= 1'b0;
    end
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_modulo_arbiter.sv
// Bench for modulo_arbiter with a behavioural 5-cycle modulo unit.
// Honours MODULO_ARBITER_WATCHDOG_EN in the same way as the design.
module tb_modulo_arbiter;

  localparam int DW      = 8;
  localparam int NR      = 4;
  localparam int IW      = 2;
  localparam int AW      = 2 * DW + 1;
  localparam int MOD_LAT = 5;
  localparam int TMO     = 64;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [NR-1:0]          req_valid = '0;
  logic [NR-1:0][AW-1:0]  req_a = '0;
  logic [NR-1:0][DW-1:0]  req_mod = '0;
  logic [NR-1:0]          req_ready;
  logic [NR-1:0]          rsp_valid;
  logic [DW-1:0]          rsp_data;
  logic                   rsp_err;
  logic                   mod_start;
  logic [AW-1:0]          mod_a;
  logic [DW-1:0]          mod_modulant;
  logic [DW-1:0]          mod_out = '0;
  logic                   mod_done = 1'b0;

  modulo_arbiter #(
    .DATA_WIDTH     (DW),
    .NUM_REQ        (NR),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_a        (req_a),
    .req_mod      (req_mod),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .mod_start    (mod_start),
    .mod_a        (mod_a),
    .mod_modulant (mod_modulant),
    .mod_out      (mod_out),
    .mod_done     (mod_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural modulo unit: done stays stale for one cycle after start,
  // then rises MOD_LAT edges after the start edge unless hanging.
  int            m_cnt = 0;
  logic [DW-1:0] m_res = '0;
  bit            model_hang = 1'b0;

  always @(posedge clk) begin
    if (mod_start) begin
      m_cnt <= MOD_LAT;
      m_res <= (mod_modulant == 0) ? '0 : DW'(mod_a % AW'(mod_modulant));
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1 && !model_hang) begin
        mod_done <= 1'b1;
        mod_out  <= m_res;
      end else begin
        mod_done <= 1'b0;
      end
    end
  end

  typedef struct {
    int                    cyc;
    logic [NR-1:0]         vec;
    logic [NR-1:0]         valid;
    logic [NR-1:0][AW-1:0] a;
    logic [NR-1:0][DW-1:0] m;
  } ready_ev_t;

  typedef struct {
    int            cyc;
    logic [AW-1:0] a;
    logic [DW-1:0] m;
  } start_ev_t;

  typedef struct {
    int            cyc;
    logic [NR-1:0] vec;
    logic [DW-1:0] data;
    logic          err;
  } rsp_ev_t;

  ready_ev_t     rq[$];
  start_ev_t     sq[$];
  rsp_ev_t       pq[$];
  int            err_cnt = 0;
  logic [NR-1:0] ready_snap = '0;

  // Event recorder, sampling mid-cycle.
  always @(negedge clk) begin
    ready_snap = req_ready;
    if (req_ready != '0)
      rq.push_back('{cyc: cyc, vec: req_ready, valid: req_valid, a: req_a, m: req_mod});
    if (mod_start)
      sq.push_back('{cyc: cyc, a: mod_a, m: mod_modulant});
    if (rsp_valid != '0)
      pq.push_back('{cyc: cyc, vec: rsp_valid, data: rsp_data, err: rsp_err});
    if (rsp_err === 1'b1) err_cnt++;
  end

  int n_cmp = 0;
  int n_fail = 0;
  int rd_r = 0, rd_s = 0, rd_p = 0;
  int model_last = NR - 1;
  int ops_left[NR];
  bit persist[NR];

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first valid index after the previous grant, wrapping.
  function automatic int rr_pick(input logic [NR-1:0] v, input int last);
    for (int off = 1; off <= NR; off++) begin
      int c;
      c = (last + off) % NR;
      if (((v >> c) & NR'(1)) != '0) return c;
    end
    return -1;
  endfunction

  // Advance one cycle; requesters accepted last cycle reload or drop.
  task automatic step_cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (ready_snap[IW'(i)] && !persist[i]) begin
        if (ops_left[i] > 1) begin
          ops_left[i]--;
          req_a[IW'(i)]   = AW'($urandom_range(0, (1 << AW) - 1));
          req_mod[IW'(i)] = DW'($urandom_range(1, 255));
        end else begin
          ops_left[i] = 0;
          req_valid[IW'(i)] = 1'b0;
        end
      end
    end
  endtask

  task automatic apply_stimulus(input int idx, input int a, input int m, input int ops);
    req_a[IW'(idx)]     = AW'(a);
    req_mod[IW'(idx)]   = DW'(m);
    ops_left[idx]       = ops;
    req_valid[IW'(idx)] = 1'b1;
  endtask

  task automatic wait_rsp(input int target, input int budget, input string tag);
    int b;
    b = 0;
    while (pq.size() < target && b < budget) begin
      step_cycle();
      b++;
    end
    check_output(tag, pq.size(), target);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_req_ready"}, req_ready, 0);
    check_output({tag, "_rsp_valid"}, rsp_valid, 0);
    check_output({tag, "_rsp_data"}, rsp_data, 0);
    check_output({tag, "_rsp_err"}, rsp_err, 0);
    check_output({tag, "_mod_start"}, mod_start, 0);
    check_output({tag, "_mod_a"}, mod_a, 0);
    check_output({tag, "_mod_modulant"}, mod_modulant, 0);
  endtask

  // Compare the next n recorded transactions with the reference model.
  task automatic verify_ops(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      int            e;
      logic [AW-1:0] a_e;
      logic [DW-1:0] m_e;
      ready_ev_t     r;
      start_ev_t     s;
      rsp_ev_t       p;
      r = rq[rd_r];
      s = sq[rd_s];
      p = pq[rd_p];
      e = rr_pick(r.valid, model_last);
      a_e = r.a[IW'(e)];
      m_e = r.m[IW'(e)];
      check_output({tag, "_grant"}, r.vec, NR'(1) << e);
      check_output({tag, "_start_cyc"}, s.cyc - r.cyc, 1);
      check_output({tag, "_mod_a"}, s.a, a_e);
      check_output({tag, "_mod_modulant"}, s.m, m_e);
      check_output({tag, "_rsp_vec"}, p.vec, NR'(1) << e);
      check_output({tag, "_rsp_data"}, p.data, DW'(a_e % AW'(m_e)));
      check_output({tag, "_rsp_err"}, p.err, 0);
      check_output({tag, "_latency"}, p.cyc - r.cyc, MOD_LAT + 3);
      if (k + 1 < n)
        check_output({tag, "_serial"}, rq[rd_r + 1].cyc > p.cyc, 1);
      model_last = e;
      rd_r++;
      rd_s++;
      rd_p++;
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: bench did not complete");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int total;
    int b;
    foreach (ops_left[i]) begin
      ops_left[i] = 0;
      persist[i]  = 1'b0;
    end

    // Reset with a request pending: nothing may be accepted.
    $display("[TB] reset");
    reset = 1'b1;
    apply_stimulus(1, 5, 3, 1);
    repeat (3) step_cycle();
    check_output("ready_in_reset", req_ready, 0);
    req_valid = '0;
    check_reset_outputs("reset");
    reset = 1'b0;
    model_last = NR - 1;
    repeat (2) step_cycle();
    check_output("idle_no_grant", rq.size(), 0);

    // Single request.
    $display("[TB] single request");
    apply_stimulus(2, 1000, 7, 1);
    wait_rsp(rd_p + 1, 40, "single_done");
    verify_ops(1, "single");
    check_output("single_const_data", pq[rd_p - 1].data, 6);
    check_output("single_grant_count", rq.size(), rd_r);

    // Contention among all four.
    $display("[TB] contention");
    for (int i = 0; i < NR; i++) apply_stimulus(i, 300, 13, 1);
    wait_rsp(rd_p + 4, 80, "contend_done");
    verify_ops(4, "contend");
    for (int k = 1; k <= 4; k++)
      check_output("contend_const_data", pq[rd_p - k].data, 1);

    // A request withdrawn before grant is skipped.
    $display("[TB] withdrawn request");
    apply_stimulus(0, 4242, 11, 1);
    b = 0;
    while (rq.size() <= rd_r && b < 10) begin step_cycle(); b++; end
    repeat (2) step_cycle();
    apply_stimulus(1, 9, 4, 1);
    repeat (2) step_cycle();
    req_valid[1] = 1'b0;
    wait_rsp(rd_p + 1, 40, "skip_done");
    repeat (10) step_cycle();
    verify_ops(1, "skip");
    check_output("skip_no_extra_grant", rq.size(), rd_r);

    // Fairness with two permanent requesters.
    $display("[TB] fairness");
    persist[0] = 1'b1;
    persist[3] = 1'b1;
    apply_stimulus(0, 600, 7, 1);
    apply_stimulus(3, 601, 9, 1);
    b = 0;
    while (rq.size() < rd_r + 6 && b < 120) begin step_cycle(); b++; end
    req_valid = '0;
    persist[0] = 1'b0;
    persist[3] = 1'b0;
    wait_rsp(rd_p + 6, 40, "fair_done");
    for (int k = 0; k < 5; k++)
      check_output("fair_alternate", rq[rd_r + k].vec !== rq[rd_r + k + 1].vec, 1);
    verify_ops(6, "fair");

    // Randomized rounds.
    for (int round = 0; round < 3; round++) begin
      $display("[TB] random round %0d", round);
      total = 0;
      for (int i = 0; i < NR; i++) begin
        if ($urandom_range(0, 2) != 0) begin
          int k;
          k = $urandom_range(1, 3);
          apply_stimulus(i, $urandom_range(0, (1 << AW) - 1), $urandom_range(1, 255), k);
          total += k;
        end
      end
      if (total == 0) begin
        apply_stimulus(1, $urandom_range(0, (1 << AW) - 1), $urandom_range(1, 255), 1);
        total = 1;
      end
      wait_rsp(rd_p + total, 20 * total + 20, "rand_done");
      verify_ops(total, "rand");
    end

    // Reset during WAIT aborts the operation silently.
    $display("[TB] reset mid-operation");
    apply_stimulus(2, 100, 9, 1);
    b = 0;
    while (sq.size() <= rd_s && b < 20) begin step_cycle(); b++; end
    step_cycle();
    reset = 1'b1;
    step_cycle();
    check_reset_outputs("reset_midop");
    reset = 1'b0;
    repeat (20) step_cycle();
    check_output("abort_no_rsp", pq.size(), rd_p);
    check_output("abort_grant_count", rq.size(), rd_r + 1);
    check_output("abort_grant_idx", rq[rd_r].vec, 4'b0100);
    rd_r++;
    rd_s++;
    model_last = NR - 1;
    apply_stimulus(0, 255, 16, 1);
    apply_stimulus(3, 77, 5, 1);
    wait_rsp(rd_p + 2, 60, "after_reset_done");
    check_output("after_reset_first_idx", rq[rd_r].vec, 4'b0001);
    verify_ops(2, "after_reset");
    check_output("after_reset_const_data", pq[rd_p - 2].data, 15);

    // Modulo unit that never finishes.
    $display("[TB] hung modulo unit");
    model_hang = 1'b1;
    apply_stimulus(1, 500, 3, 1);
`ifdef MODULO_ARBITER_WATCHDOG_EN
    wait_rsp(rd_p + 1, 150, "wd_done");
    check_output("wd_grant", rq[rd_r].vec, 4'b0010);
    check_output("wd_rsp_vec", pq[rd_p].vec, 4'b0010);
    check_output("wd_rsp_err", pq[rd_p].err, 1);
    check_output("wd_rsp_data", pq[rd_p].data, 0);
    check_output("wd_wait_cycles", pq[rd_p].cyc - (sq[rd_s].cyc + 1), TMO);
    rd_r++;
    rd_s++;
    rd_p++;
    model_last = 1;
`else
    repeat (200) step_cycle();
    check_output("nowd_no_rsp", pq.size(), rd_p);
    check_output("nowd_err_seen", err_cnt, 0);
    check_output("nowd_rsp_err", rsp_err, 0);
    reset = 1'b1;
    step_cycle();
    reset = 1'b0;
    check_output("nowd_grant_count", rq.size(), rd_r + 1);
    rd_r++;
    rd_s++;
    model_last = NR - 1;
`endif
    model_hang = 1'b0;
    repeat (2) step_cycle();
    apply_stimulus(2, 50, 6, 1);
    wait_rsp(rd_p + 1, 40, "recover_done");
    verify_ops(1, "recover");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
